imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder serving the fetch side of the core: it accepts word-fetch requests from the IFU over a valid/ready request channel and returns instruction words in order over a valid/ready response channel after a fixed pipeline latency. It holds the instruction store, a program-load write port used by the testbench/boot path, a latency pipeline and a credit-controlled response FIFO so that no fetch is ever dropped under backpressure. It sits between IFU and the instruction storage, directly below the fetch stage feeding IDU.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit instruction words; power of two
- BASE_ADDR, 32'h0000_0000, byte address of word 0
- LATENCY, 2, request-accept to response-available cycles; legal 1..4
- RSP_FIFO_DEPTH, 4, response FIFO entries and outstanding-request limit; power of two, >= 2

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid_i  in  1  fetch request valid
- req_ready_o  out  1  responder can accept a request
- req_addr_i  in  32  byte address of fetch
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  consumer accepts response
- rsp_inst_o  out  32  instruction word
- rsp_addr_o  out  32  address echoed from the request
- rsp_err_o  out  1  misaligned or out-of-range fetch
- ld_we_i  in  1  program-load write enable
- ld_addr_i  in  32  program-load byte address
- ld_data_i  in  32  program-load word

## Operation
- Reset (rst_n low, asynchronous): pipeline valids, FIFO pointers and the outstanding counter clear; rsp_valid_o=0, rsp_inst_o=0, rsp_addr_o=0, rsp_err_o=0; req_ready_o=1 once the counter is 0. Memory contents are not reset.
- Request accepted on a rising edge with req_valid_i && req_ready_o.
- Word index = (req_addr_i - BASE_ADDR) >> 2. Error if req_addr_i[1:0] != 0 or the index >= DEPTH_WORDS; an errored response returns rsp_inst_o=32'h0000_0013 (NOP), rsp_err_o=1. Otherwise returns the stored word, rsp_err_o=0.
- Outstanding counter = in-flight pipeline entries + FIFO occupancy; +1 on accept, -1 on response handshake (rsp_valid_o && rsp_ready_i), unchanged when both occur. req_ready_o = (counter < RSP_FIFO_DEPTH), so the FIFO can never overflow.
- Responses return strictly in request order.
- Load port: ld_we_i writes ld_data_i to the word at ld_addr_i on the rising edge; misaligned or out-of-range load writes are ignored silently. Loads are accepted every cycle regardless of fetch traffic.
- Same-cycle load and fetch to the same word: the fetch returns the old data (read-before-write).
- While rsp_valid_o=1 and rsp_ready_i=0, rsp_inst_o/rsp_addr_o/rsp_err_o hold stable.

## Timing
- Request accepted at edge N -> memory read at edge N (read-before-write) -> LATENCY-1 further pipeline stages -> pushed to the FIFO -> rsp_valid_o high in the cycle after edge N+LATENCY when the FIFO was empty. Minimum latency is exactly LATENCY cycles.
- Throughput: one request and one response per cycle when rsp_ready_i is held at 1; req_ready_o stays at 1 continuously in that case.
- Under full backpressure req_ready_o drops after exactly RSP_FIFO_DEPTH accepts; it rises in the same cycle the counter falls below the limit (the next cycle after a response handshake).
- Reset asserted mid-operation discards all in-flight and buffered responses immediately; the first response after reset release corresponds to the first request accepted after release.

## Test plan
- Load words 0..7 with 32'h1000_0000+i, then stream fetch addresses 0x0,0x4,...,0x1C with rsp_ready_i=1 -> rsp_valid_o first high LATENCY cycles after the first accept, then eight consecutive responses with data 0x1000_0000..0x1000_0007 and matching rsp_addr_o; req_ready_o never drops.
- Hold rsp_ready_i=0 and issue continuous requests -> exactly RSP_FIFO_DEPTH accepted, then req_ready_o=0; release rsp_ready_i -> all four responses in order, with no loss or duplication.
- Fetch 0x2 and 4*DEPTH_WORDS -> both responses have rsp_err_o=1 and rsp_inst_o=0x0000_0013, in order between surrounding good fetches.
- Word 5 = 0xAAAA_AAAA; in the same cycle, write 0x5555_5555 to 0x14 and fetch 0x14, then fetch 0x14 again -> first response 0xAAAA_AAAA, second 0x5555_5555.
- With three requests outstanding, pulse rst_n low for one cycle -> rsp_valid_o=0 immediately, counter=0, req_ready_o=1 after release, and no stale responses appear; a new fetch returns the correct data.
- Randomly toggle rsp_ready_i during a 100-fetch stream -> response outputs are stable while stalled and the response sequence equals the request sequence.

Source files
------------

// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder for the fetch path.
// Accepts word fetches on a valid/ready request channel, reads the
// instruction store at the accept edge (read-before-write against the
// load port), carries the result through a LATENCY-deep valid pipeline
// into a response FIFO, and returns responses in order on a valid/ready
// response channel. An outstanding counter (pipeline + FIFO) gates
// req_ready so the FIFO can never overflow.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid_i/req_ready_o    fetch request handshake
//   req_addr_i [31:0]          fetch byte address
//   rsp_valid_o/rsp_ready_i    response handshake
//   rsp_inst_o [31:0]          instruction word (NOP on error)
//   rsp_addr_o [31:0]          echoed request address
//   rsp_err_o                  misaligned / out-of-range fetch
//   ld_we_i, ld_addr_i, ld_data_i  program-load write port
module imem_responder #(
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned LATENCY        = 2,
  parameter int unsigned RSP_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_inst_o,
  output logic [31:0] rsp_addr_o,
  output logic        rsp_err_o,
  input  logic        ld_we_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_data_i
);
  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam int unsigned PW     = $clog2(RSP_FIFO_DEPTH);
  localparam int unsigned CW     = $clog2(RSP_FIFO_DEPTH + 1);
  localparam int unsigned STAGES = LATENCY - 1;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [CW-1:0] CREDITS = CW'(RSP_FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } rsp_t;

  logic [31:0]   mem [DEPTH_WORDS];
  rsp_t          pipe [LATENCY];
  rsp_t          fifo [RSP_FIFO_DEPTH];
  logic [STAGES:0] vld_pipe;
  logic [PW:0]   wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;

  logic [31:0] req_idx, ld_idx;
  logic        req_err, ld_ok, accept, pop, push, fifo_empty;
  rsp_t        rd_ent, head;

  always_comb begin
    req_idx     = (req_addr_i - BASE_ADDR) >> 2;
    ld_idx      = (ld_addr_i - BASE_ADDR) >> 2;
    req_err     = (req_addr_i[1:0] != 2'b00) || (req_idx >= DEPTH_WORDS);
    ld_ok       = ld_we_i && (ld_addr_i[1:0] == 2'b00) && (ld_idx < DEPTH_WORDS);
    rd_ent.inst = req_err ? NOP : mem[req_idx[AW-1:0]];
    rd_ent.addr = req_addr_i;
    rd_ent.err  = req_err;
  end

  assign req_ready_o = (cnt < CREDITS);
  assign accept      = req_valid_i && req_ready_o;
  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign rsp_valid_o = !fifo_empty;
  assign pop         = rsp_valid_o && rsp_ready_i;
  assign push        = vld_pipe[STAGES];

  // Outputs read straight from the FIFO head, so they hold while stalled;
  // forced to zero when nothing is buffered.
  assign head       = fifo[rd_ptr[PW-1:0]];
  assign rsp_inst_o = fifo_empty ? '0 : head.inst;
  assign rsp_addr_o = fifo_empty ? '0 : head.addr;
  assign rsp_err_o  = fifo_empty ? 1'b0 : head.err;

  // Store: the fetch path reads the pre-edge contents combinationally, so a
  // same-edge load to the same word is seen only by later fetches.
  always_ff @(posedge clk) begin
    if (ld_ok) mem[ld_idx[AW-1:0]] <= ld_data_i;
  end

  // Data pipeline shifts every cycle; vld_pipe says which slots are live.
  always_ff @(posedge clk) begin
    pipe[0] <= rd_ent;
    for (int s = 1; s < LATENCY; s++) pipe[s] <= pipe[s-1];
  end

  // No full check: the credit counter already bounds occupancy.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr[PW-1:0]] <= pipe[STAGES];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
    end else begin
      vld_pipe[0] <= accept;
      for (int s = 1; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// Randomized + directed bench for imem_responder against a queue-based
// reference: every accepted fetch becomes an expected response carrying
// its accept edge; the head is due LATENCY edges after acceptance.
module tb_imem_responder;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam int unsigned FD    = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic ld_we = 1'b0;
  logic [31:0] req_addr = '0, rsp_inst, rsp_addr, ld_addr = '0, ld_data = '0;

  imem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT),
                   .RSP_FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_inst_o(rsp_inst), .rsp_addr_o(rsp_addr), .rsp_err_o(rsp_err),
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data));

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
    int          acc_edge;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mm [DEPTH];
  int n_chk = 0, n_fail = 0, n_acc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  // Drive one cycle's inputs (called just after a falling edge), check the
  // outputs against the model, then advance the model across the next edge.
  task automatic step(input logic rv, input logic [31:0] ra, input logic rr,
                      input logic lw, input logic [31:0] la, input logic [31:0] ldd);
    logic exp_ready, exp_valid, err;
    logic [31:0] idx;
    exp_t e;
    req_valid = rv; req_addr = ra; rsp_ready = rr;
    ld_we = lw; ld_addr = la; ld_data = ldd;
    #1;
    exp_ready = (q.size() < FD);
    exp_valid = (q.size() > 0) && (edge_cnt >= q[0].acc_edge + int'(LAT));
    chk("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      chk("rsp_inst", rsp_inst, q[0].inst);
      chk("rsp_addr", rsp_addr, q[0].addr);
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, q[0].err});
    end
    if (exp_valid && rr) void'(q.pop_front());
    if (rv && exp_ready) begin
      idx = (ra - BASE) / 4;
      err = (ra % 4 != 0) || (idx >= DEPTH);
      e.inst = err ? 32'h0000_0013 : mm[idx];
      e.addr = ra;
      e.err = err;
      e.acc_edge = edge_cnt + 1;
      q.push_back(e);
      n_acc++;
    end
    idx = (la - BASE) / 4;
    if (lw && la % 4 == 0 && idx < DEPTH) mm[idx] = ldd;
    @(negedge clk);
  endtask

  task automatic idle(input logic rr, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, rr, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic fetch(input logic [31:0] a, input logic rr);
    step(1'b1, a, rr, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] a, la;
    int budget;
    // Reset state
    @(negedge clk);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_rsp_inst", rsp_inst, 32'h0);
    chk("rst_rsp_addr", rsp_addr, 32'h0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
    rst_n = 1'b1;

    // Program load: words 0..7 directed, 8..63 random
    for (int i = 0; i < 64; i++)
      step(1'b0, 32'h0, 1'b1, 1'b1, 32'(i * 4), (i < 8) ? 32'h1000_0000 + 32'(i) : $urandom);

    // Streaming at full throughput
    for (int i = 0; i < 8; i++) fetch(32'(i * 4), 1'b1);
    idle(1'b1, LAT + 2);

    // Full backpressure, then drain
    for (int i = 0; i < 8; i++) fetch(32'(i * 4 + 32), 1'b0);
    idle(1'b0, 2);
    idle(1'b1, 8);
    chk("bp_drained", 32'(q.size()), 32'h0);

    // Error fetches between good ones
    fetch(32'h0000_0008, 1'b1);
    fetch(32'h0000_0002, 1'b1);
    fetch(32'(4 * DEPTH), 1'b1);
    fetch(32'h0000_000C, 1'b1);
    idle(1'b1, LAT + 2);

    // Read-before-write on the same word
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h14, 32'hAAAA_AAAA);
    step(1'b1, 32'h14, 1'b1, 1'b1, 32'h14, 32'h5555_5555);
    fetch(32'h14, 1'b1);
    idle(1'b1, LAT + 2);
    chk("rbw_word5", mm[5], 32'h5555_5555);

    // Reset with three outstanding
    for (int i = 0; i < 3; i++) fetch(32'(i * 4), 1'b0);
    idle(1'b0, LAT);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("midrst_req_ready", {31'b0, req_ready}, 32'h1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1, 3);
    fetch(32'h0000_0018, 1'b1);
    idle(1'b1, LAT + 2);

    // Random stream: 100 fetches, random backpressure and loads
    n_acc = 0;
    budget = 0;
    while (n_acc < 100 && budget < 3000) begin
      case ($urandom_range(0, 9))
        0:       a = 32'h0000_1000 + 32'($urandom_range(0, 255)) * 4;
        1:       a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
        default: a = 32'($urandom_range(0, 63)) * 4;
      endcase
      la = 32'($urandom_range(0, 63)) * 4;
      if ($urandom_range(0, 7) == 0) la = la + 32'($urandom_range(1, 3));
      step($urandom_range(0, 3) != 0, a, $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) == 0, la, $urandom);
      budget++;
    end
    chk("rand_accepted", 32'(n_acc), 32'd100);
    budget = 0;
    while (q.size() > 0 && budget < 200) begin
      idle(1'b1, 1);
      budget++;
    end
    chk("rand_drained", 32'(q.size()), 32'h0);
    idle(1'b1, 2);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule
